sudoku_map_reader: RTL and testbench

Sequential reader for the puzzle library's flat map buses: 15 solution maps of 81 cells × 4-bit digit, and 15 visibility masks of 81 cells × 2 bits. On a start request it selects one map and streams its 81 cells, one per accepted transfer, in row-major order. Each transfer carries the cell's coordinates, digit and visibility over a valid/ready handshake. It sits between the constant map library and the game board loader, which writes cells into board RAM as they arrive.

---
 rtl/sudoku_map_reader.sv | 143 ++++++++++++++
 tb/tb_sudoku_map_reader.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sudoku_map_reader.sv
// Streams one map of the puzzle library, one cell per accepted valid/ready
// transfer in row-major order, with coordinates, digit and visibility.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold their last values
// STREAM | cell_valid high, presenting the top cell of the shift registers
// FINISH | one-cycle done pulse, then back to IDLE
module sudoku_map_reader #(
  parameter int NUM_MAPS = 15,
  parameter int CELLS    = 81,
  parameter int DIGIT_W  = 4,
  parameter int VIS_W    = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [3:0]                        map_sel,
  input  logic [NUM_MAPS*CELLS*DIGIT_W-1:0] maps_in,
  input  logic [NUM_MAPS*CELLS*VIS_W-1:0]   vis_in,
  input  logic                              cell_ready,
  output logic                              cell_valid,
  output logic [6:0]                        cell_index,
  output logic [3:0]                        cell_row,
  output logic [3:0]                        cell_col,
  output logic [DIGIT_W-1:0]                cell_digit,
  output logic                              cell_visible,
  output logic                              busy,
  output logic                              done,
  output logic                              error
);

  localparam int MAP_DW = CELLS * DIGIT_W;
  localparam int MAP_VW = CELLS * VIS_W;

  typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

  state_t              r_state;
  logic [MAP_DW-1:0]   r_dig;
  logic [MAP_VW-1:0]   r_vis;
  logic [6:0]          r_index;
  logic [3:0]          r_row;
  logic [3:0]          r_col;
  logic                r_valid;
  logic                r_busy;
  logic                r_done;
  logic                r_error;

  logic [MAP_DW-1:0]   w_dig_sel;
  logic [MAP_VW-1:0]   w_vis_sel;
  logic [DIGIT_W-1:0]  w_digit;
  logic                w_bad_digit;
  logic                w_xfer;

  // Map 0 sits in the most significant slice of each bus.
  always_comb begin
    w_dig_sel = '0;
    w_vis_sel = '0;
    for (int m = 0; m < NUM_MAPS; m++) begin
      if (map_sel == 4'(m)) begin
        w_dig_sel = maps_in[NUM_MAPS*MAP_DW-1 - m*MAP_DW -: MAP_DW];
        w_vis_sel = vis_in[NUM_MAPS*MAP_VW-1 - m*MAP_VW -: MAP_VW];
      end
    end
  end

  assign w_digit     = r_dig[MAP_DW-1 -: DIGIT_W];
  assign w_bad_digit = (w_digit == '0) || (w_digit > DIGIT_W'(9));
  assign w_xfer      = r_valid && cell_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_dig   <= '0;
      r_vis   <= '0;
      r_index <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (map_sel < 4'(NUM_MAPS)) begin
              r_dig   <= w_dig_sel;
              r_vis   <= w_vis_sel;
              r_index <= '0;
              r_row   <= '0;
              r_col   <= '0;
              r_error <= 1'b0;
              r_valid <= 1'b1;
              r_state <= STREAM;
            end else begin
              r_error <= 1'b1;
              r_done  <= 1'b1;
              r_state <= FINISH;
            end
          end
        end
        STREAM: begin
          if (w_xfer) begin
            r_dig <= {r_dig[MAP_DW-DIGIT_W-1:0], {DIGIT_W{1'b0}}};
            r_vis <= {r_vis[MAP_VW-VIS_W-1:0], {VIS_W{1'b0}}};
            if (w_bad_digit) r_error <= 1'b1;
            if (r_index == 7'(CELLS-1)) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= FINISH;
            end else begin
              r_index <= r_index + 7'd1;
              if (r_col == 4'd8) begin
                r_col <= 4'd0;
                r_row <= r_row + 4'd1;
              end else begin
                r_col <= r_col + 4'd1;
              end
            end
          end
        end
        FINISH: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cell_valid   = r_valid;
  assign cell_index   = r_index;
  assign cell_row     = r_row;
  assign cell_col     = r_col;
  assign cell_digit   = w_digit;
  assign cell_visible = &r_vis[MAP_VW-1 -: VIS_W];
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;

endmodule

// File: tb/tb_sudoku_map_reader.sv
// Directed bench for sudoku_map_reader: table of stream requests checked
// cell-by-cell against a bench-built library, plus reset/start corner cases.
module tb_sudoku_map_reader;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [3:0]    map_sel;
  logic [4859:0] maps_in;
  logic [2429:0] vis_in;
  logic          cell_ready;
  logic          cell_valid;
  logic [6:0]    cell_index;
  logic [3:0]    cell_row;
  logic [3:0]    cell_col;
  logic [3:0]    cell_digit;
  logic          cell_visible;
  logic          busy;
  logic          done;
  logic          error;

  sudoku_map_reader dut (
    .clk(clk), .reset(reset), .start(start), .map_sel(map_sel),
    .maps_in(maps_in), .vis_in(vis_in), .cell_ready(cell_ready),
    .cell_valid(cell_valid), .cell_index(cell_index), .cell_row(cell_row),
    .cell_col(cell_col), .cell_digit(cell_digit), .cell_visible(cell_visible),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  int         dig_ref [15][81];
  logic [1:0] vis_ref [15][81];
  int         perm    [9] = '{2, 4, 9, 8, 5, 6, 7, 3, 1};

  typedef struct {
    logic [3:0] sel;
    int         pct;
    int         exp_xfers;
    logic       exp_err;
  } req_t;

  req_t reqs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] outs();
    return {cell_index, cell_row, cell_col, cell_digit, cell_visible};
  endfunction

  task automatic run_stream(input logic [3:0] sel, input int pct, input int inject_at,
                            input logic exp_err, output int ntr);
    int   k = 0;
    bit   errs = 0, stalled = 0, got_done = 0, prev_last = 0;
    logic [19:0] held = '0;
    @(negedge clk);
    start = 1'b1; map_sel = sel;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
      if (done) begin
        got_done = 1;
        chk("done_after_last", 32'(prev_last || (sel >= 15 && k == 0)), 1);
        chk("done_busy", busy, 1);
        chk("done_valid", cell_valid, 0);
        chk("done_error", error, exp_err);
        start = 1'b0;
      end else begin
        chk("busy", busy, 1);
        chk("valid", cell_valid, 1);
        chk("err_track", error, errs);
        if (stalled) chk("hold", outs(), held);
        cell_ready = ($urandom_range(99) < pct);
        prev_last = 0;
        if (cell_valid && cell_ready) begin
          chk("index", cell_index, k);
          chk("row", cell_row, k / 9);
          chk("col", cell_col, k % 9);
          chk("digit", cell_digit, dig_ref[sel][k]);
          chk("visible", cell_visible, vis_ref[sel][k] == 2'b11);
          if (sel == 0 && k < 9) chk("map0_row0", cell_digit, perm[k]);
          if (dig_ref[sel][k] == 0 || dig_ref[sel][k] > 9) errs = 1;
          k++;
          prev_last = (k == 81);
        end
        stalled = !cell_ready;
        held = outs();
        start = (inject_at >= 0 && k == inject_at);
        map_sel = 4'd1;
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!got_done) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("done_pulse_width", done, 0);
    chk("busy_drop", busy, 0);
    chk("error_sticky", error, exp_err);
    ntr = k;
  endtask

  initial begin
    int n;
    int idx;
    reset = 1'b1; start = 1'b0; map_sel = '0; cell_ready = 1'b0;
    maps_in = '0; vis_in = '0;

    for (int m = 0; m < 15; m++)
      for (int c = 0; c < 81; c++) begin
        dig_ref[m][c] = perm[(3*((c/9)%3) + (c/9)/3 + (c%9) + m) % 9];
        vis_ref[m][c] = 2'((m + c) % 4);
        if (m == 14) vis_ref[m][c] = (c % 3 == 0) ? 2'b11 : (c % 3 == 1) ? 2'b00 : 2'b01;
      end
    dig_ref[5][40] = 0;
    for (int m = 0; m < 15; m++)
      for (int c = 0; c < 81; c++) begin
        idx = 4859 - 324*m - 4*c;
        maps_in[idx -: 4] = 4'(dig_ref[m][c]);
        idx = 2429 - 162*m - 2*c;
        vis_in[idx -: 2] = vis_ref[m][c];
      end

    reqs[0] = '{4'd0,  100, 81, 1'b0};
    reqs[1] = '{4'd14, 100, 81, 1'b0};
    reqs[2] = '{4'd3,  50,  81, 1'b0};
    reqs[3] = '{4'd5,  100, 81, 1'b1};
    reqs[4] = '{4'd15, 100, 0,  1'b1};

    #12;
    chk("rst_outs", outs(), 0);
    chk("rst_flags", {cell_valid, busy, done, error}, 0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_stream(reqs[i].sel, reqs[i].pct, -1, reqs[i].exp_err, n);
      chk("xfer_count", n, reqs[i].exp_xfers);
    end

    // Error from the invalid request clears on the next good start.
    run_stream(4'd2, 100, -1, 1'b0, n);
    chk("map2_count", n, 81);

    // Mid-stream reset at index 37.
    @(negedge clk); start = 1'b1; map_sel = 4'd0; cell_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 200 && cell_index != 7'd37; i++) @(negedge clk);
    chk("reach_37", cell_index, 37);
    reset = 1'b1;
    #1;
    chk("midrst_outs", outs(), 0);
    chk("midrst_flags", {cell_valid, busy, done, error}, 0);
    @(negedge clk); reset = 1'b0;
    run_stream(4'd0, 100, 20, 1'b0, n);
    chk("restart_count", n, 81);

    // Start coinciding with the done pulse is ignored.
    @(negedge clk); start = 1'b1; map_sel = 4'd2; cell_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 200 && !done; i++) @(negedge clk);
    chk("done_seen", done, 1);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("ign_valid", cell_valid, 0);
    chk("ign_busy", busy, 0);
    @(negedge clk);
    chk("ign_valid2", cell_valid, 0);
    run_stream(4'd2, 100, -1, 1'b0, n);
    chk("after_ign_count", n, 81);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
